// File: rtl/kvs_req_fifo.sv
// kvs_req_fifo: first-word-fall-through request queue between eth_top and db_top.
// Requests arriving while full (with no pop in the same cycle) are dropped and counted.
module kvs_req_fifo #(
    parameter int KEY_SIZE   = 96,
    parameter int FLAG_SIZE  = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL_LVL  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_SIZE-1:0]   in_key,
    input  logic [FLAG_SIZE-1:0]  in_flag,
    input  logic                  in_valid,
    output logic [KEY_SIZE-1:0]   out_key,
    output logic [FLAG_SIZE-1:0]  out_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic [31:0]           drop_cnt
);
    localparam int W     = KEY_SIZE + FLAG_SIZE;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [31:0]           drop_q, drop_d;
    logic [W-1:0]          head_q, head_d;
    logic                  afull_q, push, pop, full, acc;

    // head_q is a registered copy of the queue head so the outputs hold
    // their last value when empty instead of exposing stale storage.
    always_comb begin
        push    = in_valid && (in_flag != '0);
        pop     = out_valid && out_ready;
        full    = level_q == LW'(DEPTH);
        acc     = push && (!full || pop);
        rd_d    = rd_q + DEPTH_LOG2'(pop);
        wr_d    = wr_q + DEPTH_LOG2'(acc);
        level_d = level_q + LW'(acc) - LW'(pop);
        drop_d  = (push && !acc && drop_q != '1) ? drop_q + 32'd1 : drop_q;
        head_d  = (acc && level_q == LW'(pop)) ? {in_key, in_flag} :
                  (pop && level_d != '0)       ? mem_q[rd_d]        : head_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            drop_q  <= '0;
            head_q  <= '0;
            afull_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            afull_q <= level_d >= LW'(AFULL_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_q] <= {in_key, in_flag};
    end

    assign {out_key, out_flag} = head_q;
    assign out_valid           = level_q != '0;
    assign level               = level_q;
    assign almost_full         = afull_q;
    assign drop_cnt            = drop_q;
endmodule

// File: tb/tb_kvs_req_fifo.sv
// tb_kvs_req_fifo: directed tests for kvs_req_fifo against a queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_kvs_req_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] in_key;
    logic [3:0]  in_flag;
    logic        in_valid;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        almost_full;
    logic [31:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [99:0] q[$];
    logic [99:0] mhead;
    logic [31:0] mdrop;

    kvs_req_fifo dut (
        .clk(clk), .rst_n(rst_n), .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
        .out_key(out_key), .out_flag(out_flag), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mhead = '0;
        mdrop = '0;
    endtask

    // Queue semantics: a pop frees a slot before the same-cycle push is judged.
    task automatic model_update();
        logic do_pop, do_push;
        if (!rst_n) begin
            model_clear();
        end else begin
            do_pop  = q.size() != 0 && out_ready;
            do_push = in_valid && in_flag != 4'h0;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < 16) q.push_back({in_key, in_flag});
                else if (mdrop != 32'hFFFF_FFFF) mdrop++;
            end
            if (q.size() != 0) mhead = q[0];
        end
    endtask

    task automatic compare();
        chk("m_valid", out_valid, q.size() != 0);
        chk("m_level", level, q.size());
        chk("m_afull", almost_full, q.size() >= 12);
        chk("m_drop", drop_cnt, mdrop);
        chk("m_head", {out_key, out_flag}, mhead);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic push(input logic [95:0] k, input logic [3:0] f);
        in_valid = 1'b1;
        in_key   = k;
        in_flag  = f;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_key = '0; in_flag = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_key", out_key, 96'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // single entry, held 5 cycles, then popped
        push(96'h1, 4'h1);
        chk("single_valid", out_valid, 1'b1);
        chk("single_key", out_key, 96'h1);
        chk("single_level", level, 5'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("single_hold", out_key, 96'h1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_valid", out_valid, 1'b0);
        chk("single_pop_level", level, 5'd0);
        chk("single_pop_keyhold", out_key, 96'h1);

        // fill and overflow
        for (int i = 1; i <= 20; i++) begin
            push(96'(i), 4'h1);
            if (i == 11) chk("afull_11", almost_full, 1'b0);
            if (i == 12) chk("afull_12", almost_full, 1'b1);
        end
        chk("fill_level", level, 5'd16);
        chk("fill_drop", drop_cnt, 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_key", out_key, 96'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 1'b0);

        // full with simultaneous push and pop
        for (int i = 101; i <= 116; i++) push(96'(i), 4'h1);
        chk("full2_level", level, 5'd16);
        out_ready = 1'b1;
        push(96'd99, 4'h3);
        chk("pp_drop", drop_cnt, 32'd4);
        chk("pp_level", level, 5'd16);
        chk("pp_head", out_key, 96'd102);
        for (int i = 0; i < 15; i++) step();
        chk("pp_last_key", out_key, 96'd99);
        chk("pp_last_flag", out_flag, 4'h3);
        chk("pp_last_level", level, 5'd1);
        step();
        out_ready = 1'b0;
        chk("pp_empty", out_valid, 1'b0);

        // asynchronous reset mid-burst, no clock edge needed
        for (int i = 0; i < 3; i++) push(96'(300 + i), 4'h5);
        in_valid = 1'b1; in_key = 96'd400; in_flag = 4'h5;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_level", level, 5'd0);
        chk("arst_drop", drop_cnt, 32'd0);
        chk("arst_key", out_key, 96'h0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // no-op filtering
        for (int i = 0; i < 16; i++) push(96'(200 + i), i[0] ? 4'h2 : 4'h0);
        chk("noop_level", level, 5'd8);
        chk("noop_drop", drop_cnt, 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("noop_key", out_key, 96'(201 + 2 * j));
            chk("noop_flag", out_flag, 4'h2);
            step();
        end
        chk("noop_empty", out_valid, 1'b0);

        // streaming
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_key  = {$urandom, $urandom, $urandom};
            in_flag = 4'($urandom_range(1, 15));
            step();
            chk("stream_level", level <= 5'd1, 1'b1);
        end
        in_valid = 1'b0;
        step(); step();
        chk("stream_drop", drop_cnt, 32'd0);
        chk("stream_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
